// File: rtl/pipeline_pkg.sv
// pipeline_pkg: memory-stage opcode constants, access-size encoding and FSM state type
// Contents: MEM_NONE/MEM_LOAD/MEM_STORE opcodes, SZ_B..SZ_D log2-byte sizes, mem_state_t
package pipeline_pkg;
  localparam logic [31:0] MEM_NONE = 32'd0;
  localparam logic [31:0] MEM_LOAD = 32'd1;
  localparam logic [31:0] MEM_STORE = 32'd2;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
endpackage

// File: rtl/pipeline_mem_if.sv
// pipeline_mem_if: data-memory request/grant/response bus
// Signals: req/addr/we/wdata/wstrb (stage to memory), gnt/rvalid/rdata (memory to stage)
// Modports: master = memory stage, slave = data memory
interface pipeline_mem_if #(parameter int ADDR_WIDTH = 64, parameter int DATA_WIDTH = 64);
  logic req;
  logic gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [7:0] wstrb;
  logic rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (output req, addr, we, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave (input req, addr, we, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/pipeline_mem_align.sv
// mem_align: combinational store lane shift/strobe and load lane extract/extend
// Ports: off (byte offset in doubleword), size ([1:0] log2 bytes, [2] unsigned),
//        sdata/rdata in, wdata/wstrb/ldata out
import pipeline_pkg::*;
module mem_align #(parameter int W = 64) (
  input  logic [2:0]   off,
  input  logic [2:0]   size,
  input  logic [W-1:0] sdata,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] wdata,
  output logic [7:0]   wstrb,
  output logic [W-1:0] ldata
);
  logic [7:0] mask;
  logic [W-1:0] lane;
  logic sx;
  assign mask = 8'((9'd1 << (4'd1 << size[1:0])) - 9'd1);
  // bytes shifted past lane 7 simply fall off the doubleword
  assign wstrb = mask << off;
  assign wdata = sdata << {off, 3'b000};
  assign lane = rdata >> {off, 3'b000};
  assign sx = ~size[2];
  always_comb begin
    ldata = size[1:0] == SZ_B ? {{(W-8){sx & lane[7]}}, lane[7:0]} :
            size[1:0] == SZ_H ? {{(W-16){sx & lane[15]}}, lane[15:0]} :
            size[1:0] == SZ_W ? {{(W-32){sx & lane[31]}}, lane[31:0]} : lane;
  end
endmodule

// File: rtl/pipeline_mem.sv
// pipeline_mem: memory-access stage between execute and write-back
// Ports: clk, reset (async active-low), ready/in_valid handshake with execute,
//        ex_res/r2_val_mem/mem_dst_reg/next_mem_opcode/next_mem_operation_size/ecall_mem in,
//        dmem (pipeline_mem_if.master) to data memory, wb_* registered write-back record out
// Option: MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of issuing them
import pipeline_pkg::*;
module pipeline_mem #(parameter int ADDR_WIDTH = 64, parameter int DATA_WIDTH = 64) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val_mem,
  input  logic [4:0]            mem_dst_reg,
  input  logic [31:0]           next_mem_opcode,
  input  logic [2:0]            next_mem_operation_size,
  input  logic                  ecall_mem,
  pipeline_mem_if.master        dmem,
  output logic                  wb_valid,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ecall,
  output logic                  wb_fault
);
  mem_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] sd_q, wdata, ldata;
  logic [4:0] dst_q;
  logic [2:0] size_q;
  logic we_q, ecall_q, req;
  logic accept, is_mem, misalign, go_mem, trap, ret_alu, ret_st, ret_ld;
  logic [7:0] wstrb;
  assign ready = state_q == IDLE;
  assign accept = ready & in_valid;
  assign is_mem = next_mem_opcode == MEM_LOAD || next_mem_opcode == MEM_STORE;
`ifdef MEM_MISALIGN_TRAP_EN
  logic [3:0] amask;
  assign amask = (4'd1 << next_mem_operation_size[1:0]) - 4'd1;
  assign misalign = |(ex_res[2:0] & amask[2:0]);
`else
  assign misalign = 1'b0;
`endif
  assign go_mem = accept & is_mem & ~misalign;
  assign trap = accept & is_mem & misalign;
  assign ret_alu = accept & ~is_mem;
  assign ret_st = state_q == REQ && dmem.gnt && we_q;
  assign ret_ld = state_q == WAIT && dmem.rvalid;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE && go_mem ? REQ :
              state_q == REQ && dmem.gnt ? (we_q ? IDLE : WAIT) :
              ret_ld ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_q <= '0;
      sd_q <= '0;
      dst_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      ecall_q <= 1'b0;
    end else if (go_mem) begin
      addr_q <= ex_res[ADDR_WIDTH-1:0];
      sd_q <= r2_val_mem;
      dst_q <= mem_dst_reg;
      size_q <= next_mem_operation_size;
      we_q <= next_mem_opcode == MEM_STORE;
      ecall_q <= ecall_mem;
    end
  mem_align #(.W(DATA_WIDTH)) u_align (
    .off(addr_q[2:0]), .size(size_q), .sdata(sd_q), .rdata(dmem.rdata),
    .wdata(wdata), .wstrb(wstrb), .ldata(ldata)
  );
  // bus outputs are zero outside REQ so reset drops them without a register stage
  assign req = state_q == REQ;
  assign dmem.req = req;
  assign dmem.addr = req ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign dmem.we = req & we_q;
  assign dmem.wdata = req & we_q ? wdata : '0;
  assign dmem.wstrb = req & we_q ? wstrb : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_dst_reg <= '0;
      wb_data <= '0;
      wb_ecall <= 1'b0;
      wb_fault <= 1'b0;
    end else begin
      wb_valid <= ret_alu | trap | ret_st | ret_ld;
      if (ret_alu | trap) begin
        wb_dst_reg <= trap ? 5'd0 : mem_dst_reg;
        wb_data <= ex_res;
        wb_ecall <= ecall_mem;
        wb_fault <= trap;
      end else if (ret_st | ret_ld) begin
        wb_dst_reg <= ret_ld ? dst_q : 5'd0;
        wb_data <= ret_ld ? ldata : '0;
        wb_ecall <= ecall_q;
        wb_fault <= 1'b0;
      end
    end
endmodule

// File: doc/pipeline_mem.md
# pipeline_mem

Memory-access stage sitting directly downstream of the execute stage and upstream of write-back. It accepts the execute result, store operand, destination register and memory opcode/size, issues at most one load or store to the data-memory port through a request/grant/response handshake, aligns and extends load data, and presents a registered write-back record. While an access is outstanding it applies backpressure to execute through `ready`.

## Interface
- `ADDR_WIDTH`, 64, address width; `ex_res` is the effective address for memory ops.
- `DATA_WIDTH`, 64, register and memory-port data width (doubleword port).
- `clk  in  1  clock; all state changes on rising edge`
- `reset  in  1  asynchronous, active-low; the stage is in reset while reset==0`
- `ready  out  1  stage can accept this cycle (drives execute's next_stage_ready)`
- `in_valid  in  1  execute/mem pipeline register holds a live instruction`
- `ex_res  in  DATA_WIDTH  ALU result / effective address`
- `r2_val_mem  in  DATA_WIDTH  store data`
- `mem_dst_reg  in  5  destination register`
- `next_mem_opcode  in  32  0=none, 1=load, 2=store, any other value treated as none`
- `next_mem_operation_size  in  3  [1:0]=log2 bytes (0..3 → 1/2/4/8 B), [2]=unsigned load`
- `ecall_mem  in  1  environment call marker, passed through`
- `dmem_req  out  1  request valid`; `dmem_gnt  in  1  request accepted`
- `dmem_addr  out  ADDR_WIDTH  doubleword-aligned address (low 3 bits zero)`
- `dmem_we  out  1  store`; `dmem_wdata  out  DATA_WIDTH  lane-shifted store data`; `dmem_wstrb  out  8  byte enables`
- `dmem_rvalid  in  1  load response valid`; `dmem_rdata  in  DATA_WIDTH  aligned doubleword`
- `wb_valid  out  1`; `wb_dst_reg  out  5`; `wb_data  out  DATA_WIDTH`; `wb_ecall  out  1`; `wb_fault  out  1` (see Configuration)

## Operation
- States: IDLE, REQ, WAIT. `ready` = (state==IDLE). Accept = ready & in_valid.
- Accept of non-memory op: next edge wb_valid=1, wb_data=ex_res, wb_dst_reg, wb_ecall=ecall_mem; state stays IDLE.
- Accept of load/store: capture address, store data, dst, size, ecall into internal registers; go REQ. wb_valid=0.
- REQ: dmem_req=1, outputs driven from captured registers and stable until grant. On dmem_gnt: store → IDLE with wb_valid=1, wb_dst_reg=0 next edge; load → WAIT.
- WAIT: on dmem_rvalid, extract byte lane at addr[2:0]*8, sign-extend (size[2]=0) or zero-extend (size[2]=1); next edge wb_valid=1, wb_data=extended value, state → IDLE.
- Store align: wdata = r2_val_mem << (addr[2:0]*8); wstrb = ((1<<(1<<size[1:0]))-1) << addr[2:0].
- dmem_rvalid outside WAIT is ignored. dmem_gnt outside REQ is ignored.
- wb_valid is a one-cycle pulse per retired instruction; write-back never stalls.

## Timing
- Reset values: state=IDLE, ready=1, dmem_req=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_dst_reg=0, wb_data=0, wb_ecall=0, wb_fault=0.
- Non-memory latency: 1 cycle accept→wb_valid.
- Store: dmem_req the cycle after accept; wb_valid the cycle after grant (min 2 cycles).
- Load: dmem_req the cycle after accept; response may arrive ≥1 cycle after grant; wb_valid cycle after rvalid (min 3 cycles).
- Grant in the first REQ cycle is legal; rvalid same cycle as grant is not (ignored).
- Reset asserted mid-access: immediate return to IDLE, dmem_req drops asynchronously; a later response is dropped.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: an access whose addr is not a multiple of its size issues no request; next edge wb_valid=1, wb_fault=1, wb_dst_reg=0, wb_data=address. Undefined: no check, wb_fault tied 0, lane logic uses addr[2:0] as-is (bytes beyond lane 7 are dropped).

## Structure
- Shared `pipeline_pkg`: mem opcode constants (MEM_NONE/LOAD/STORE), size encoding, `mem_state_t` enum.
- One sub-module `mem_align`: combinational store shift/strobe generation and load extract/extend.

## Test plan
- Non-mem op, ex_res=0x1234, dst=5 → next cycle wb_valid=1, wb_data=0x1234, wb_dst_reg=5, ready held 1.
- Load byte signed, addr=0x1003, rdata=0x00000000_80FF0000 (byte3=0x80) → wb_data=0xFFFF_FFFF_FFFF_FF80.
- Load half unsigned, addr=0x2006, rdata=0xBEEF_0000_0000_0000 → wb_data=0xBEEF; with grant delayed 3 cycles ready=0 throughout.
- Store word, addr=0x3004, r2=0xDEADBEEF → dmem_addr=0x3000, wstrb=0xF0, wdata[63:32]=0xDEADBEEF, wb_valid cycle after grant.
- Reset pulled low in WAIT, then rvalid after release → no wb_valid, ready=1.
- With macro: load word at addr=0x4002 → no dmem_req, wb_fault=1, wb_data=0x4002.
